// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RV32IM execute stage: single-cycle ALU plus iterative MUL/DIV/REM unit
package ex_stage_pkg;
  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] rs2_data;
    alu_op_t     alu_op;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_width;
    logic        mem_unsigned;
  } id_ex_reg_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_width;
    logic        mem_unsigned;
  } ex_mem_reg_t;
endpackage

module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MD_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  id_ex_reg_t  id_ex_reg,
  output ex_mem_reg_t ex_mem_next,
  output logic        ex_busy
);
  localparam int CW = (MD_ITERS > 1) ? $clog2(MD_ITERS) : 1;
  localparam logic [CW-1:0] LAST = CW'(MD_ITERS - 1);

  typedef enum logic [1:0] {EX_IDLE, EX_RUN, EX_DONE} ex_state_t;
  ex_state_t state_q, state_d;

  logic [CW-1:0]     cnt_q;
  logic [2*XLEN:0]   acc_q, acc_d;
  logic [XLEN-1:0]   b_mag_q, result_q, result_d, alu_res, a_mag, b_mag;
  alu_op_t           md_op_q;
  logic              neg_q, dz_q, neg_d;
  logic              is_m, start, a_signed, b_signed, md_is_mul;
  logic [XLEN:0]     mul_sum, rem_sh;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    is_m  = id_ex_reg.alu_op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                                     ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    start = (state_q == EX_IDLE) && id_ex_reg.valid && is_m && !flush;
    a_signed = id_ex_reg.alu_op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    b_signed = id_ex_reg.alu_op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
    a_mag = (a_signed && id_ex_reg.op_a[XLEN-1]) ? -id_ex_reg.op_a : id_ex_reg.op_a;
    b_mag = (b_signed && id_ex_reg.op_b[XLEN-1]) ? -id_ex_reg.op_b : id_ex_reg.op_b;
    // Quotient sign follows both operands, remainder sign follows the dividend.
    case (id_ex_reg.alu_op)
      ALU_MUL, ALU_MULH, ALU_DIV: neg_d = id_ex_reg.op_a[XLEN-1] ^ id_ex_reg.op_b[XLEN-1];
      ALU_MULHSU, ALU_REM:        neg_d = id_ex_reg.op_a[XLEN-1];
      default:                    neg_d = 1'b0;
    endcase
  end

  always_comb begin
    case (id_ex_reg.alu_op)
      ALU_ADD:  alu_res = id_ex_reg.op_a + id_ex_reg.op_b;
      ALU_SUB:  alu_res = id_ex_reg.op_a - id_ex_reg.op_b;
      ALU_SLL:  alu_res = id_ex_reg.op_a << id_ex_reg.op_b[4:0];
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(id_ex_reg.op_a) < $signed(id_ex_reg.op_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, id_ex_reg.op_a < id_ex_reg.op_b};
      ALU_XOR:  alu_res = id_ex_reg.op_a ^ id_ex_reg.op_b;
      ALU_SRL:  alu_res = id_ex_reg.op_a >> id_ex_reg.op_b[4:0];
      ALU_SRA:  alu_res = $unsigned($signed(id_ex_reg.op_a) >>> id_ex_reg.op_b[4:0]);
      ALU_OR:   alu_res = id_ex_reg.op_a | id_ex_reg.op_b;
      ALU_AND:  alu_res = id_ex_reg.op_a & id_ex_reg.op_b;
      ALU_LUI:  alu_res = id_ex_reg.op_b;
      default:  alu_res = '0;
    endcase
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    md_is_mul = md_op_q inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    mul_sum   = acc_q[2*XLEN:XLEN] + (acc_q[0] ? {1'b0, b_mag_q} : '0);
    rem_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff      = {1'b0, rem_sh} - {2'b0, b_mag_q};
    if (md_is_mul)
      acc_d = {1'b0, mul_sum, acc_q[XLEN-1:1]};
    else if (diff[XLEN+1])
      acc_d = {rem_sh, acc_q[XLEN-2:0], 1'b0};
    else
      acc_d = {diff[XLEN:0], acc_q[XLEN-2:0], 1'b1};

    prod = neg_q ? -acc_d[2*XLEN-1:0] : acc_d[2*XLEN-1:0];
    quo  = acc_d[XLEN-1:0];
    rem  = acc_d[2*XLEN-1:XLEN];
    case (md_op_q)
      ALU_MUL:                        result_d = prod[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: result_d = prod[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:              result_d = dz_q ? '1 : (neg_q ? -quo : quo);
      ALU_REM, ALU_REMU:              result_d = neg_q ? -rem : rem;
      default:                        result_d = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EX_IDLE: if (start) state_d = EX_RUN;
      EX_RUN:  if (flush) state_d = EX_IDLE;
               else if (cnt_q == LAST) state_d = EX_DONE;
      EX_DONE: if (flush || !stall) state_d = EX_IDLE;
      default: state_d = EX_IDLE;
    endcase
    ex_busy = start || (state_q == EX_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EX_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      b_mag_q  <= '0;
      result_q <= '0;
      md_op_q  <= ALU_ADD;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else if (start) begin
      cnt_q   <= '0;
      acc_q   <= {{(XLEN+1){1'b0}}, a_mag};
      b_mag_q <= b_mag;
      md_op_q <= id_ex_reg.alu_op;
      neg_q   <= neg_d;
      dz_q    <= (id_ex_reg.op_b == '0);
    end else if (state_q == EX_RUN) begin
      cnt_q <= cnt_q + 1'b1;
      acc_q <= acc_d;
      if (cnt_q == LAST) result_q <= result_d;
    end
  end

  always_comb begin
    ex_mem_next              = '0;
    ex_mem_next.valid        = is_m ? (state_q == EX_DONE) : 1'b1;
    ex_mem_next.alu_result   = is_m ? result_q : alu_res;
    ex_mem_next.rs2_data     = id_ex_reg.rs2_data;
    ex_mem_next.rd           = id_ex_reg.rd;
    ex_mem_next.reg_write    = id_ex_reg.reg_write;
    ex_mem_next.mem_to_reg   = id_ex_reg.mem_to_reg;
    ex_mem_next.mem_read     = id_ex_reg.mem_read && !is_m;
    ex_mem_next.mem_write    = id_ex_reg.mem_write && !is_m;
    ex_mem_next.mem_width    = id_ex_reg.mem_width;
    ex_mem_next.mem_unsigned = id_ex_reg.mem_unsigned;
    if (flush || !id_ex_reg.valid || !ex_mem_next.valid) ex_mem_next = '0;
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - table, random and corner-sequence checks of ex_stage
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk, rst, stall, flush, ex_busy;
  id_ex_reg_t  id_ex_reg;
  ex_mem_reg_t ex_mem_next;
  int total = 0, bad = 0;

  ex_stage dut (.clk(clk), .rst(rst), .stall(stall), .flush(flush),
                .id_ex_reg(id_ex_reg), .ex_mem_next(ex_mem_next), .ex_busy(ex_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    alu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic bit is_mop(alu_op_t op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  // Reference arithmetic straight from the RV32IM definitions, using 64-bit math.
  function automatic logic [31:0] ref_model(alu_op_t op, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      ALU_ADD:    return a + b;
      ALU_SUB:    return a - b;
      ALU_SLL:    return a << b[4:0];
      ALU_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU:   return (ua < ub) ? 32'd1 : 32'd0;
      ALU_XOR:    return a ^ b;
      ALU_SRL:    return a >> b[4:0];
      ALU_SRA:    begin p = sa >>> b[4:0]; return p[31:0]; end
      ALU_OR:     return a | b;
      ALU_AND:    return a & b;
      ALU_LUI:    return b;
      ALU_MUL:    begin p = sa * sb; return p[31:0]; end
      ALU_MULH:   begin p = sa * sb; return p[63:32]; end
      ALU_MULHSU: begin p = sa * $signed(ub); return p[63:32]; end
      ALU_MULHU:  begin up = ua * ub; return up[63:32]; end
      ALU_DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      ALU_REM: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      ALU_DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
      ALU_REMU:   return (b == 0) ? a : a % b;
      default:    return 32'd0;
    endcase
  endfunction

  function automatic id_ex_reg_t make_id(alu_op_t op, logic [31:0] a, logic [31:0] b);
    id_ex_reg_t d;
    d = '0;
    d.valid        = 1'b1;
    d.op_a         = a;
    d.op_b         = b;
    d.alu_op       = op;
    d.rs2_data     = $urandom;
    d.rd           = 5'($urandom);
    d.reg_write    = 1'($urandom);
    d.mem_to_reg   = 1'($urandom);
    d.mem_read     = 1'($urandom);
    d.mem_write    = 1'($urandom);
    d.mem_width    = 2'($urandom);
    d.mem_unsigned = 1'($urandom);
    return d;
  endfunction

  function automatic ex_mem_reg_t expect_out(id_ex_reg_t d);
    ex_mem_reg_t e;
    e = '0;
    e.valid        = 1'b1;
    e.alu_result   = ref_model(d.alu_op, d.op_a, d.op_b);
    e.rs2_data     = d.rs2_data;
    e.rd           = d.rd;
    e.reg_write    = d.reg_write;
    e.mem_to_reg   = d.mem_to_reg;
    e.mem_read     = d.mem_read && !is_mop(d.alu_op);
    e.mem_write    = d.mem_write && !is_mop(d.alu_op);
    e.mem_width    = d.mem_width;
    e.mem_unsigned = d.mem_unsigned;
    return e;
  endfunction

  // Presents one instruction, waits for its result, then lets the pipeline advance to a bubble.
  task automatic run_op(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, input string tag);
    id_ex_reg_t  d;
    ex_mem_reg_t o;
    int lat = 0, busy_n = 0;
    bit ok = 0;
    @(negedge clk);
    d = make_id(op, a, b);
    id_ex_reg = d;
    o = '0;
    while (lat < 100) begin
      #1;
      if (ex_busy) busy_n++;
      if (ex_mem_next.valid) begin ok = 1; o = ex_mem_next; break; end
      @(negedge clk);
      lat++;
    end
    res = o.alu_result;
    check({tag, "_done"}, 128'(ok), 128'(1));
    check({tag, "_out"}, 128'(o), 128'(expect_out(d)));
    check({tag, "_lat"}, 128'(lat), is_mop(op) ? 128'(33) : 128'(0));
    check({tag, "_busy"}, 128'(busy_n), is_mop(op) ? 128'(33) : 128'(0));
    @(posedge clk);
    #1 id_ex_reg = '0;
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin : main
    logic [31:0] r;
    id_ex_reg_t  d;
    int n;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; id_ex_reg = '0;
    #12;
    check("reset_busy", 128'(ex_busy), 128'(0));
    check("reset_out", 128'(ex_mem_next), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    tbl.push_back('{ALU_ADD,    32'd5,          32'hFFFFFFFF, 32'd4});
    tbl.push_back('{ALU_SUB,    32'd3,          32'd5,        32'hFFFFFFFE});
    tbl.push_back('{ALU_SLL,    32'd1,          32'h23,       32'd8});
    tbl.push_back('{ALU_SLT,    32'hFFFFFFFF,   32'd1,        32'd1});
    tbl.push_back('{ALU_SLTU,   32'hFFFFFFFF,   32'd1,        32'd0});
    tbl.push_back('{ALU_XOR,    32'hF0F0,       32'hFF00,     32'h0FF0});
    tbl.push_back('{ALU_SRL,    32'h80000000,   32'd31,       32'd1});
    tbl.push_back('{ALU_SRA,    32'h80000000,   32'd4,        32'hF8000000});
    tbl.push_back('{ALU_OR,     32'hF0,         32'h0F,       32'hFF});
    tbl.push_back('{ALU_AND,    32'hF0,         32'h3C,       32'h30});
    tbl.push_back('{ALU_LUI,    32'd9,          32'h12345000, 32'h12345000});
    tbl.push_back('{ALU_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB});
    tbl.push_back('{ALU_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE});
    tbl.push_back('{ALU_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'd0});
    tbl.push_back('{ALU_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF});
    tbl.push_back('{ALU_DIV,    32'd100,        32'd0,        32'hFFFFFFFF});
    tbl.push_back('{ALU_REM,    32'd100,        32'd0,        32'd100});
    tbl.push_back('{ALU_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000});
    tbl.push_back('{ALU_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0});
    tbl.push_back('{ALU_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD});
    tbl.push_back('{ALU_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF});
    tbl.push_back('{ALU_REMU,   32'd100,        32'd7,        32'd2});

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, $sformatf("tbl%0d_%s", i, tbl[i].op.name()));
      check($sformatf("tbl%0d_%s_val", i, tbl[i].op.name()), 128'(r), 128'(tbl[i].exp));
    end

    // Bubble and flushed single-cycle instructions produce an all-zero EX/MEM word.
    @(negedge clk);
    d = make_id(ALU_ADD, 32'd1, 32'd2);
    d.valid = 1'b0;
    id_ex_reg = d;
    #1 check("bubble_out", 128'(ex_mem_next), 128'(0));
    d.valid = 1'b1;
    id_ex_reg = d;
    flush = 1'b1;
    #1 check("flush_add_out", 128'(ex_mem_next), 128'(0));
    flush = 1'b0;
    id_ex_reg = '0;

    // DIVU 100/7 completing under stall: result held in EX_DONE until stall drops.
    @(negedge clk);
    stall = 1'b1;
    id_ex_reg = make_id(ALU_DIVU, 32'd100, 32'd7);
    n = 0;
    #1;
    while (!ex_mem_next.valid && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check("stall_lat", 128'(n), 128'(33));
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall_hold%0d_valid", k), 128'(ex_mem_next.valid), 128'(1));
      check($sformatf("stall_hold%0d_res", k), 128'(ex_mem_next.alu_result), 128'(14));
      check($sformatf("stall_hold%0d_busy", k), 128'(ex_busy), 128'(0));
      @(negedge clk); #1;
    end
    stall = 1'b0;
    #1 check("stall_release_valid", 128'(ex_mem_next.valid), 128'(1));
    @(posedge clk); #1;
    check("stall_idle_busy", 128'(ex_busy), 128'(1));
    check("stall_idle_valid", 128'(ex_mem_next.valid), 128'(0));
    id_ex_reg = '0;
    #1 check("stall_idle_bubble_busy", 128'(ex_busy), 128'(0));

    // Flush at iteration 10 of a DIV discards it; the next ADD and MUL behave normally.
    @(negedge clk);
    id_ex_reg = make_id(ALU_DIV, 32'd1000, 32'd3);
    repeat (11) @(negedge clk);
    #1 check("flush_run_busy", 128'(ex_busy), 128'(1));
    flush = 1'b1;
    #1 check("flush_run_valid", 128'(ex_mem_next.valid), 128'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    id_ex_reg = '0;
    #1 check("flush_next_busy", 128'(ex_busy), 128'(0));
    check("flush_next_valid", 128'(ex_mem_next.valid), 128'(0));
    run_op(ALU_ADD, 32'd2, 32'd3, r, "after_flush_add");
    check("after_flush_add_val", 128'(r), 128'(5));
    run_op(ALU_MUL, 32'd6, 32'd9, r, "after_flush_mul");

    // Asynchronous reset in the middle of a MUL abandons it.
    @(negedge clk);
    id_ex_reg = make_id(ALU_MUL, 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    #1 check("rst_mid_busy_before", 128'(ex_busy), 128'(1));
    id_ex_reg = '0;
    rst = 1'b1;
    #1 check("rst_mid_busy_after", 128'(ex_busy), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    run_op(ALU_MUL, 32'd3, 32'd4, r, "after_rst_mul");
    check("after_rst_mul_val", 128'(r), 128'(12));

    for (int i = 0; i < 40; i++) begin
      alu_op_t op;
      op = alu_op_t'($urandom_range(0, 10));
      run_op(op, rnd_opnd(), rnd_opnd(), r, $sformatf("rnd_alu%0d_%s", i, op.name()));
    end
    for (int i = 0; i < 24; i++) begin
      alu_op_t op;
      op = alu_op_t'($urandom_range(11, 18));
      run_op(op, rnd_opnd(), rnd_opnd(), r, $sformatf("rnd_md%0d_%s", i, op.name()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
